// File: rtl/mode_counter_pkg.sv
// Shared encodings for the mode counter: operation codes and controller states.
package mode_counter_pkg;

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_DEC  = 2'b01;
   localparam logic [1:0] OP_INC  = 2'b10;
   localparam logic [1:0] OP_SHR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/mode_counter.sv
// Saturating load/decrement/increment/shift counter with sticky saturation,
// terminal-count pulse, reload register and an IDLE/RUN/DONE controller.
module mode_counter
   import mode_counter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             en,
   input  logic [1:0]       op,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             max,
   output logic             tc,
   output logic             sat,
   output logic             busy
);

   generate
      if (WIDTH < 2 || STEP < 1 || STEP > (2 ** WIDTH) - 1) begin : g_bad_params
         $error("mode_counter: STEP must lie in 1 .. 2**WIDTH-1 and WIDTH >= 2");
      end
   endgenerate

   localparam logic [WIDTH:0] STEP_EXT = (WIDTH + 1)'(STEP);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic [WIDTH-1:0] reload_reg, reload_next;
   logic             sat_reg, sat_next;
   logic             tc_reg, tc_next;
   logic [WIDTH:0]   diff, sum;
   logic             reload_op;

   // One extra bit exposes the borrow/carry used for saturation.
   assign diff      = {1'b0, count_reg} - STEP_EXT;
   assign sum       = {1'b0, count_reg} + STEP_EXT;
   assign reload_op = en && auto_reload && (op == OP_DEC || op == OP_SHR);

   always_comb begin
      count_next  = count_reg;
      reload_next = reload_reg;
      sat_next    = sat_reg;
      tc_next     = 1'b0;
      if (load) begin
         count_next  = load_value;
         reload_next = load_value;
         sat_next    = 1'b0;
      end else if (en && state_reg == RUN) begin
         case (op)
            OP_DEC: begin
               if (diff[WIDTH]) begin
                  count_next = '0;
                  sat_next   = 1'b1;
                  tc_next    = 1'b1;
               end else begin
                  count_next = diff[WIDTH-1:0];
                  tc_next    = (diff[WIDTH-1:0] == '0);
               end
            end
            OP_INC: begin
               if (sum[WIDTH]) begin
                  count_next = '1;
                  sat_next   = 1'b1;
               end else begin
                  count_next = sum[WIDTH-1:0];
               end
            end
            OP_SHR: begin
               count_next = count_reg >> 1;
               tc_next    = (count_reg[WIDTH-1:1] == '0);
            end
            default: count_next = count_reg;
         endcase
      end else if (state_reg == DONE && reload_op) begin
         count_next = reload_reg;
      end
   end

   // tc_next doubles as the "RUN op reached zero" indication.
   always_comb begin
      state_next = state_reg;
      if (load) begin
         state_next = (load_value == '0) ? DONE : RUN;
      end else if (state_reg == RUN && tc_next) begin
         state_next = DONE;
      end else if (state_reg == DONE && reload_op && reload_reg != '0) begin
         state_next = RUN;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg  <= IDLE;
         count_reg  <= '0;
         reload_reg <= '0;
         sat_reg    <= 1'b0;
         tc_reg     <= 1'b0;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         reload_reg <= reload_next;
         sat_reg    <= sat_next;
         tc_reg     <= tc_next;
      end
   end

   assign count = count_reg;
   assign zero  = (count_reg == '0);
   assign max   = (count_reg == '1);
   assign tc    = tc_reg;
   assign sat   = sat_reg;
   assign busy  = (state_reg == RUN);

endmodule
